// File: rtl/pixel_readout_ctrl.sv
// Pixel array readout: selects one row at a time, captures its column bus after settling, then streams pixels.
// Latency: first pixel SETTLE_CYCLES+2 cycles after start; out_ready low stalls only in STREAM, holding outputs stable.
module pixel_readout_ctrl #(
  parameter int PIXEL_BITS    = 8,
  parameter int ARRAY_WIDTH   = 2,
  parameter int ARRAY_HEIGHT  = 2,
  parameter int SETTLE_CYCLES = 1,
  localparam int ROW_W = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1,
  localparam int COL_W = (ARRAY_WIDTH > 1) ? $clog2(ARRAY_WIDTH) : 1,
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  output logic                              busy,
  output logic [ARRAY_HEIGHT-1:0]           read_row,
  input  logic [ARRAY_WIDTH*PIXEL_BITS-1:0] col_data,
  output logic [PIXEL_BITS-1:0]             out_data,
  output logic [ROW_W-1:0]                  out_row,
  output logic [COL_W-1:0]                  out_col,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic                              frame_done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    CAPTURE = 3'd2,
    STREAM  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                                       state_q, state_d;
  logic [ROW_W-1:0]                             row_q, row_d;
  logic [COL_W-1:0]                             col_q, col_d;
  logic [CNT_W-1:0]                             cnt_q, cnt_d;
  logic [ARRAY_WIDTH-1:0][PIXEL_BITS-1:0]       line_q, line_d;
  logic                                         last_col;
  logic                                         last_row;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    busy       = 1'b0;
    read_row   = '0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_row    = '0;
    out_col    = '0;
    out_last   = 1'b0;
    frame_done = 1'b0;
    last_col   = (col_q == COL_W'(ARRAY_WIDTH - 1));
    last_row   = (row_q == ROW_W'(ARRAY_HEIGHT - 1));

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SELECT;
          row_d   = '0;
          col_d   = '0;
          cnt_d   = '0;
        end
      end
      SELECT: begin
        busy          = 1'b1;
        read_row[row_q] = 1'b1;
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CAPTURE: begin
        // Bus is still driven by the selected row during this cycle.
        busy          = 1'b1;
        read_row[row_q] = 1'b1;
        line_d        = col_data;
        col_d         = '0;
        state_d       = STREAM;
      end
      STREAM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = line_q[col_q];
        out_row   = row_q;
        out_col   = col_q;
        out_last  = last_col && last_row;
        if (out_ready) begin
          if (!last_col) begin
            col_d = col_q + COL_W'(1);
          end else if (!last_row) begin
            row_d   = row_q + ROW_W'(1);
            cnt_d   = '0;
            state_d = SELECT;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Self-checking bench for pixel_readout_ctrl: scoreboarded pixel stream, cycle-exact READ/frame_done timing.
module tb_pixel_readout_ctrl;
  localparam int PB = 8;
  localparam int W  = 2;
  localparam int H  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n, start, out_ready, busy, out_valid, out_last, frame_done;
  logic [H-1:0]     read_row;
  logic [W*PB-1:0]  col_data;
  logic [PB-1:0]    out_data;
  logic             out_row, out_col;
  logic [W*PB-1:0]  row_bus [H];

  logic             start3, busy3, out_valid3, out_last3, frame_done3;
  logic [H-1:0]     read_row3;
  logic [W*PB-1:0]  col_data3, bus3_val;
  logic [PB-1:0]    out_data3;
  logic             out_row3, out_col3;

  // Pixel array model: a row drives the bus only while selected, otherwise X.
  assign col_data  = (read_row == 2'b01) ? row_bus[0] : (read_row == 2'b10) ? row_bus[1] : 'x;
  assign col_data3 = (read_row3 != 2'b00) ? bus3_val : 'x;

  pixel_readout_ctrl #(.PIXEL_BITS(PB), .ARRAY_WIDTH(W), .ARRAY_HEIGHT(H), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .read_row(read_row),
    .col_data(col_data), .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .frame_done(frame_done));

  pixel_readout_ctrl #(.PIXEL_BITS(PB), .ARRAY_WIDTH(W), .ARRAY_HEIGHT(H), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .busy(busy3), .read_row(read_row3),
    .col_data(col_data3), .out_data(out_data3), .out_row(out_row3), .out_col(out_col3),
    .out_valid(out_valid3), .out_ready(1'b1), .out_last(out_last3), .frame_done(frame_done3));

  typedef struct {
    logic [PB-1:0] d;
    logic          r;
    logic          c;
    logic          l;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors  = 0;
  int   checks  = 0;
  int   pix_cnt = 0;
  bit   mon_en  = 1'b0;

  // Scoreboard monitor for the SETTLE_CYCLES=1 instance.
  always @(negedge clk) begin
    if (mon_en && reset_n && out_valid && out_ready) begin
      checks++;
      pix_cnt++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pixel_unexpected: got data=%h r%0d c%0d last=%b, required none", out_data, out_row, out_col, out_last);
      end else begin
        mon_e = exp_q.pop_front();
        if ({out_data, out_row, out_col, out_last} !== {mon_e.d, mon_e.r, mon_e.c, mon_e.l}) begin
          errors++;
          $display("FAIL pixel: got data=%h r%0d c%0d last=%b, required data=%h r%0d c%0d last=%b",
                   out_data, out_row, out_col, out_last, mon_e.d, mon_e.r, mon_e.c, mon_e.l);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  task automatic push_frame(input logic [W*PB-1:0] b0, input logic [W*PB-1:0] b1);
    exp_t x;
    logic [W*PB-1:0] b;
    for (int r = 0; r < H; r++) begin
      b = (r == 0) ? b0 : b1;
      for (int c = 0; c < W; c++) begin
        x.d = b[c*PB +: PB];
        x.r = (r == 1);
        x.c = (c == 1);
        x.l = (r == H-1) && (c == W-1);
        exp_q.push_back(x);
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; start3 = 1'b0; out_ready = 1'b1;
    bus3_val = '0; row_bus[0] = '0; row_bus[1] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({read_row, busy, out_valid, out_last, frame_done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got rr=%b busy=%b vld=%b last=%b done=%b, required all 0",
               read_row, busy, out_valid, out_last, frame_done);
    end
    checks++;
    if ({out_data, out_row, out_col} !== 10'b0) begin
      errors++;
      $display("FAIL reset_data: got data=%h r=%b c=%b, required 0", out_data, out_row, out_col);
    end
    checks++;
    if ({read_row3, busy3, out_valid3, frame_done3, out_data3} !== 13'b0) begin
      errors++;
      $display("FAIL reset_dut3: got rr=%b busy=%b vld=%b done=%b data=%h, required 0",
               read_row3, busy3, out_valid3, frame_done3, out_data3);
    end
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [H-1:0] exp_rr;
    row_bus[0] = 16'h2211; row_bus[1] = 16'h4433; out_ready = 1'b1;
    pix_cnt = 0; push_frame(16'h2211, 16'h4433); mon_en = 1'b1;
    pulse_start();
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      exp_rr = (c <= 2) ? 2'b01 : (c == 5 || c == 6) ? 2'b10 : 2'b00;
      checks++;
      if (read_row !== exp_rr) begin
        errors++; $display("FAIL basic_read_row c%0d: got %b, required %b", c, read_row, exp_rr);
      end
      checks++;
      if (frame_done !== (c == 9)) begin
        errors++; $display("FAIL basic_frame_done c%0d: got %b, required %b", c, frame_done, c == 9);
      end
      checks++;
      if (busy !== (c <= 8)) begin
        errors++; $display("FAIL basic_busy c%0d: got %b, required %b", c, busy, c <= 8);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (pix_cnt != 4 || exp_q.size() != 0) begin
      errors++; $display("FAIL basic_count: got %0d pixels, %0d pending, required 4 and 0", pix_cnt, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int   hold = 0, vcyc = 0, cyc = 0;
    bit   done = 1'b0, stalled = 1'b0;
    logic [PB+2:0] snap;
    row_bus[0] = 16'hB2A1; row_bus[1] = 16'hD4C3; out_ready = 1'b0;
    pix_cnt = 0; push_frame(16'hB2A1, 16'hD4C3);
    pulse_start();
    while (!done && cyc < 200) begin
      out_ready = out_valid && (hold == 2);
      @(negedge clk);
      if (out_valid) begin
        vcyc++;
        checks++;
        if (read_row !== 2'b00) begin
          errors++; $display("FAIL bp_read_row: got %b during stream, required 00", read_row);
        end
        if (stalled) begin
          checks++;
          if ({out_data, out_row, out_col, out_last} !== snap) begin
            errors++; $display("FAIL bp_stable: got %h, required %h", {out_data, out_row, out_col, out_last}, snap);
          end
        end
        snap    = {out_data, out_row, out_col, out_last};
        stalled = !out_ready;
        hold    = out_ready ? 0 : hold + 1;
      end else begin
        stalled = 1'b0;
      end
      if (frame_done) done = 1'b1;
      cyc++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    checks++;
    if (!done) begin
      errors++; $display("FAIL bp_timeout: frame_done not seen in %0d cycles, required completion", cyc);
    end
    checks++;
    if (vcyc != 12 || pix_cnt != 4 || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_count: got valid_cycles=%0d pixels=%0d pending=%0d, required 12 4 0", vcyc, pix_cnt, exp_q.size());
    end
  endtask

  task automatic test_start_while_busy();
    int done_cnt = 0, restart_c = 0;
    row_bus[0] = 16'h0201; row_bus[1] = 16'h0403; out_ready = 1'b1;
    pix_cnt = 0; push_frame(16'h0201, 16'h0403);
    pulse_start();
    for (int c = 1; c <= 40; c++) begin
      start = (c == 3) || (c == restart_c);
      @(negedge clk);
      if (frame_done) begin
        done_cnt++;
        if (restart_c == 0) begin
          checks++;
          if (c != 9 || pix_cnt != 4) begin
            errors++; $display("FAIL sbusy_first_done: got cycle %0d pixels %0d, required cycle 9 pixels 4", c, pix_cnt);
          end
          restart_c = c + 1;
          row_bus[0] = 16'h0605; row_bus[1] = 16'h0807;
          push_frame(16'h0605, 16'h0807);
        end
      end
      if (restart_c != 0 && c == restart_c + 1) begin
        checks++;
        if (busy !== 1'b1 || read_row !== 2'b01) begin
          errors++; $display("FAIL sbusy_restart: got busy=%b rr=%b, required 1 01", busy, read_row);
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if (done_cnt != 2 || pix_cnt != 8 || exp_q.size() != 0) begin
      errors++; $display("FAIL sbusy_count: got dones=%0d pixels=%0d pending=%0d, required 2 8 0", done_cnt, pix_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int  cyc = 0;
    bit  hit = 1'b0;
    row_bus[0] = 16'h1817; row_bus[1] = 16'h2827; out_ready = 1'b1;
    push_frame(16'h1817, 16'h2827);
    pulse_start();
    while (!hit && cyc < 30) begin
      @(negedge clk);
      if (out_valid && out_row == 1'b1) hit = 1'b1;
      else begin cyc++; @(posedge clk); #1; end
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL rst_reach_row1: row 1 stream not reached, required reached");
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({read_row, busy, out_valid, out_last, frame_done, out_data, out_row, out_col} !== 16'b0) begin
      errors++; $display("FAIL rst_outputs: got rr=%b busy=%b vld=%b data=%h r=%b c=%b, required 0",
                         read_row, busy, out_valid, out_data, out_row, out_col);
    end
    exp_q.delete();
    @(posedge clk); #1 reset_n = 1'b1;
    row_bus[0] = 16'h3231; row_bus[1] = 16'h3433;
    pix_cnt = 0; push_frame(16'h3231, 16'h3433);
    pulse_start();
    hit = 1'b0; cyc = 0;
    while (!hit && cyc < 30) begin
      @(negedge clk);
      if (cyc == 0) begin
        checks++;
        if (read_row !== 2'b01) begin
          errors++; $display("FAIL rst_restart_row: got rr=%b, required 01", read_row);
        end
      end
      if (frame_done) hit = 1'b1;
      cyc++;
      @(posedge clk); #1;
    end
    checks++;
    if (!hit || pix_cnt != 4 || exp_q.size() != 0) begin
      errors++; $display("FAIL rst_restart_frame: got done=%b pixels=%0d pending=%0d, required 1 4 0", hit, pix_cnt, exp_q.size());
    end
  endtask

  task automatic test_settle3();
    logic [H-1:0]  exp_rr;
    logic [PB-1:0] exp_px [$];
    logic [PB-1:0] want;
    int            got = 0;
    exp_px = '{8'h51, 8'h62, 8'h73, 8'h84};
    @(posedge clk); #1 start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      case (c)
        1:       bus3_val = 16'hDEAD;
        2, 3:    bus3_val = 16'h5A5A;
        4:       bus3_val = 16'h6251;
        7:       bus3_val = 16'hBEEF;
        8, 9:    bus3_val = 16'hA5A5;
        10:      bus3_val = 16'h8473;
        default: bus3_val = 16'h0000;
      endcase
      @(negedge clk);
      exp_rr = (c <= 4) ? 2'b01 : (c >= 7 && c <= 10) ? 2'b10 : 2'b00;
      checks++;
      if (read_row3 !== exp_rr) begin
        errors++; $display("FAIL s3_read_row c%0d: got %b, required %b", c, read_row3, exp_rr);
      end
      checks++;
      if (frame_done3 !== (c == 13)) begin
        errors++; $display("FAIL s3_frame_done c%0d: got %b, required %b", c, frame_done3, c == 13);
      end
      if (out_valid3) begin
        checks++;
        if (exp_px.size() == 0) begin
          errors++; $display("FAIL s3_pixel_unexpected c%0d: got %h, required none", c, out_data3);
        end else begin
          want = exp_px.pop_front();
          if (out_data3 !== want || out_last3 !== (got == 3)) begin
            errors++; $display("FAIL s3_pixel c%0d: got %h last=%b, required %h last=%b", c, out_data3, out_last3, want, got == 3);
          end
          got++;
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (got != 4) begin
      errors++; $display("FAIL s3_count: got %0d pixels, required 4", got);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_frame();
    test_settle3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
